// File: rtl/word_packer_if.sv
// word_packer_if: stream bundle around the word packer.
//   cmd_*  : command channel (word count + start, idle indication back)
//   in*    : narrow element stream into the packer (isReady/canReceive)
//   out*   : 64-bit packed word stream out of the packer, with isLast
// Modport slave is the packer's view, modport master is the driver's view.
interface word_packer_if #(
    parameter int ELEM_W = 16,
    parameter int CNT_W  = 16
);
    logic [CNT_W-1:0]  cmd_numWords;
    logic              cmd_start;
    logic              cmd_canReceive;
    logic [ELEM_W-1:0] in;
    logic              in_isReady;
    logic              in_canReceive;
    logic [63:0]       out;
    logic              out_isReady;
    logic              out_canReceive;
    logic              out_isLast;

    modport slave (
        input  cmd_numWords, cmd_start, in, in_isReady, out_canReceive,
        output cmd_canReceive, in_canReceive, out, out_isReady, out_isLast
    );

    modport master (
        output cmd_numWords, cmd_start, in, in_isReady, out_canReceive,
        input  cmd_canReceive, in_canReceive, out, out_isReady, out_isLast
    );
endinterface

// File: rtl/word_packer.sv
// word_packer: gathers ELEM_W-bit elements LSB-first into 64-bit words and
// emits a counted burst of words, flagging the final one with out_isLast.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - word_packer_if.slave: command, element input and word output
//          streams (see interface for signal list)
module word_packer #(
    parameter int ELEM_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic          clk,
    input  logic          rst,
    word_packer_if.slave  bus
);
    localparam int K    = 64 / ELEM_W;
    localparam int FC_W = (K > 1) ? $clog2(K) : 1;
    localparam logic [FC_W-1:0] LAST_SLOT = FC_W'(K - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [FC_W-1:0]   fill_cnt;
    logic [CNT_W-1:0]  words_left;
    logic [63:0]       fill_p0;
    logic [63:0]       fill_nxt;
    logic [63:0]       word_p1;
    logic              vld_p1;
    logic              last_p1;

    logic              in_open;
    logic              in_acc;
    logic              word_done;
    logic              xfer;
    logic              cmd_acc;

    // Handshake decode. The K-th element may only enter when the output
    // register is free or emptying this very cycle, so nothing is overwritten.
    always_comb begin
        in_open   = (state_q == FILL) &&
                    ((fill_cnt != LAST_SLOT) || !vld_p1 || bus.out_canReceive);
        in_acc    = in_open && bus.in_isReady;
        word_done = in_acc && (fill_cnt == LAST_SLOT);
        xfer      = vld_p1 && bus.out_canReceive;
        cmd_acc   = (state_q == IDLE) && !vld_p1 && bus.cmd_start &&
                    (bus.cmd_numWords != '0);
    end

    // Fill buffer with the current element merged into its slot; this is
    // also the completed word when the last slot is being written.
    always_comb begin
        fill_nxt = fill_p0;
        for (int i = 0; i < K; i++) begin
            if (fill_cnt == FC_W'(i)) begin
                fill_nxt[i*ELEM_W +: ELEM_W] = bus.in;
            end
        end
    end

    // Next-state logic. Non-final words keep the FSM in FILL so the stream
    // runs bubble-free; only the final word parks it in DRAIN.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cmd_acc) state_d = FILL;
            FILL:    if (word_done && (words_left == CNT_W'(1))) state_d = DRAIN;
            DRAIN:   if (xfer) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Stage p0: element accumulation and counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill_cnt   <= '0;
            words_left <= '0;
            fill_p0    <= '0;
        end else begin
            if (cmd_acc) begin
                fill_cnt   <= '0;
                words_left <= bus.cmd_numWords;
            end else begin
                if (in_acc) begin
                    fill_cnt <= word_done ? '0 : fill_cnt + FC_W'(1);
                end
                if (word_done && (words_left != '0)) begin
                    words_left <= words_left - CNT_W'(1);
                end
            end
            if (in_acc) begin
                fill_p0 <= fill_nxt;
            end
        end
    end

    // Stage p1: output word register; zeroed on transfer so out reads 0
    // whenever nothing is presented.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_p1 <= '0;
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else if (word_done) begin
            word_p1 <= fill_nxt;
            vld_p1  <= 1'b1;
            last_p1 <= (words_left == CNT_W'(1));
        end else if (xfer) begin
            word_p1 <= '0;
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end
    end

    assign bus.cmd_canReceive = (state_q == IDLE) && !vld_p1;
    assign bus.in_canReceive  = in_open;
    assign bus.out            = word_p1;
    assign bus.out_isReady    = vld_p1;
    assign bus.out_isLast     = vld_p1 && last_p1;

endmodule

// File: tb/tb_word_packer.sv
// tb_word_packer: self-checking bench for word_packer (ELEM_W=16, K=4).
// Drives and samples on the falling clock edge; expected words come from a
// table of literals or from plain shift/add arithmetic over the sent elements.
module tb_word_packer;
    localparam int ELEM_W = 16;
    localparam int CNT_W  = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    word_packer_if #(.ELEM_W(ELEM_W), .CNT_W(CNT_W)) bus ();

    word_packer #(.ELEM_W(ELEM_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int zero_err = 0;

    logic [15:0] elem_q[$];
    logic [63:0] got_q[$];
    bit          last_q[$];

    typedef struct {
        logic [15:0] e0, e1, e2, e3;
        logic [63:0] want;
    } vec_t;
    vec_t tbl[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    // Expected packed word w: element w*4+j weighted by 2^(16*j).
    function automatic logic [63:0] model_word(input int w);
        logic [63:0] acc = 64'd0;
        for (int j = 0; j < 4; j++) begin
            acc = acc + (64'(elem_q[w*4+j]) << (16 * j));
        end
        return acc;
    endfunction

    // One clock: drive at negedge, sample 1 ns later, return after posedge.
    task automatic step(input logic rdy, input logic [15:0] d, input logic ocr,
                        output bit in_f, output bit out_f, output logic [63:0] o,
                        output bit lst, output bit ordy, output bit icr);
        @(negedge clk);
        bus.in_isReady     = rdy;
        bus.in             = d;
        bus.out_canReceive = ocr;
        #1;
        icr   = bus.in_canReceive;
        ordy  = bus.out_isReady;
        in_f  = rdy && bus.in_canReceive;
        out_f = bus.out_isReady && ocr;
        o     = bus.out;
        lst   = bus.out_isLast;
        if (!bus.out_isReady && (bus.out !== 64'd0 || bus.out_isLast !== 1'b0)) zero_err++;
        @(posedge clk);
    endtask

    task automatic do_cmd(input logic [15:0] n);
        @(negedge clk);
        bus.in_isReady   = 1'b0;
        bus.cmd_numWords = n;
        bus.cmd_start    = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_start = 1'b0;
    endtask

    // Send elem_q as an nwords command with random valid/ready duty cycles.
    task automatic run_stream(input int nwords, input int in_pct, input int out_pct,
                              output int ncyc);
        int idx = 0;
        bit in_f, out_f, lst, ordy, icr;
        logic [63:0] o;
        logic rdy;
        logic [15:0] d;
        got_q.delete();
        last_q.delete();
        ncyc = 0;
        do_cmd(16'(nwords));
        while (got_q.size() < nwords && ncyc < 4000) begin
            rdy = (idx < elem_q.size()) && ($urandom_range(99) < in_pct);
            d   = rdy ? elem_q[idx] : 16'($urandom);
            step(rdy, d, ($urandom_range(99) < out_pct), in_f, out_f, o, lst, ordy, icr);
            if (in_f) idx++;
            if (out_f) begin
                got_q.push_back(o);
                last_q.push_back(lst);
            end
            ncyc++;
        end
        chk("word_count", 64'(got_q.size()), 64'(nwords));
        @(negedge clk);
        bus.in_isReady     = 1'b0;
        bus.out_canReceive = 1'b0;
        chk("idle_after_last", 64'(bus.cmd_canReceive), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, idx, first, acc8, rel, hold_err, bad, lasts;
        bit stall, in_f, out_f, lst, ordy, icr;
        logic [63:0] o;

        tbl[0] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 64'h0004_0003_0002_0001};
        tbl[1] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 64'h0000_FFFF_0000_FFFF};
        tbl[2] = '{16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D, 64'hF00D_CAFE_BEEF_DEAD};
        tbl[3] = '{16'h8000, 16'h0001, 16'h7FFF, 16'h00FF, 64'h00FF_7FFF_0001_8000};
        tbl[4] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 64'h0000_0000_0000_0000};

        bus.cmd_numWords   = '0;
        bus.cmd_start      = 1'b0;
        bus.in             = '0;
        bus.in_isReady     = 1'b0;
        bus.out_canReceive = 1'b0;
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("rst_cmd_canReceive", 64'(bus.cmd_canReceive), 64'd1);
        chk("rst_in_canReceive",  64'(bus.in_canReceive),  64'd0);
        chk("rst_out_isReady",    64'(bus.out_isReady),    64'd0);
        chk("rst_out_isLast",     64'(bus.out_isLast),     64'd0);
        chk("rst_out",            bus.out,                 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Table-driven single-word commands
        for (int r = 0; r < 5; r++) begin
            elem_q = '{tbl[r].e0, tbl[r].e1, tbl[r].e2, tbl[r].e3};
            run_stream(1, 100, (r < 3) ? 100 : 50, n);
            chk($sformatf("tbl%0d_word", r), got_q[0], tbl[r].want);
            chk($sformatf("tbl%0d_last", r), 64'(last_q[0]), 64'd1);
        end

        // Basic two-word burst at full rate
        elem_q.delete();
        for (int i = 1; i <= 8; i++) elem_q.push_back(16'(i));
        run_stream(2, 100, 100, n);
        chk("basic_word0", got_q[0], 64'h0004_0003_0002_0001);
        chk("basic_last0", 64'(last_q[0]), 64'd0);
        chk("basic_word1", got_q[1], 64'h0008_0007_0006_0005);
        chk("basic_last1", 64'(last_q[1]), 64'd1);
        chk("basic_cycles", 64'(n), 64'd9);

        // Back-pressure: hold the first word for 8 cycles
        do_cmd(16'd2);
        got_q.delete(); last_q.delete();
        idx = 0; first = -1; acc8 = -1; rel = -1; hold_err = 0; stall = 0;
        for (int c = 0; c < 40 && got_q.size() < 2; c++) begin
            step(idx < 8, 16'(idx + 1), (first >= 0) && (c >= first + 8),
                 in_f, out_f, o, lst, ordy, icr);
            if (ordy && first < 0) first = c;
            if (ordy && !out_f && got_q.size() == 0 && o !== 64'h0004_0003_0002_0001) hold_err++;
            if (idx == 7 && !icr) stall = 1;
            if (in_f && idx == 7) acc8 = c;
            if (out_f && got_q.size() == 0) rel = c;
            if (in_f) idx++;
            if (out_f) begin got_q.push_back(o); last_q.push_back(lst); end
        end
        chk("bp_stall_seen", 64'(stall), 64'd1);
        chk("bp_hold_stable", 64'(hold_err), 64'd0);
        chk("bp_release_cycle", 64'(rel), 64'(first + 8));
        chk("bp_elem8_on_release", 64'(acc8), 64'(rel));
        chk("bp_word0", got_q[0], 64'h0004_0003_0002_0001);
        chk("bp_word1", got_q[1], 64'h0008_0007_0006_0005);
        chk("bp_last1", 64'(last_q[1]), 64'd1);

        // Zero-length command
        do_cmd(16'd0);
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            step(1'b1, 16'h5555, 1'b1, in_f, out_f, o, lst, ordy, icr);
            #1;
            if (icr || ordy || bus.cmd_canReceive !== 1'b1) bad++;
        end
        chk("zero_len_idle", 64'(bad), 64'd0);

        // Command pulses while filling must be ignored
        do_cmd(16'd1);
        got_q.delete(); last_q.delete();
        idx = 0; lasts = 0;
        for (int c = 0; c < 16; c++) begin
            bus.cmd_start    = (c < 2);
            bus.cmd_numWords = 16'd3;
            step(1'b1, 16'(16'h10 + idx), 1'b1, in_f, out_f, o, lst, ordy, icr);
            if (in_f) idx++;
            if (out_f) begin got_q.push_back(o); lasts += int'(lst); end
        end
        bus.cmd_start = 1'b0;
        chk("ign_words", 64'(got_q.size()), 64'd1);
        chk("ign_lasts", 64'(lasts), 64'd1);
        chk("ign_word", got_q[0], 64'h0013_0012_0011_0010);
        chk("ign_elems", 64'(idx), 64'd4);

        // Asynchronous reset after 3 elements
        do_cmd(16'd1);
        for (int i = 0; i < 3; i++) step(1'b1, 16'h0EE0, 1'b1, in_f, out_f, o, lst, ordy, icr);
        #2 rst = 1'b0;
        #1;
        chk("arst_cmd_canReceive", 64'(bus.cmd_canReceive), 64'd1);
        chk("arst_in_canReceive",  64'(bus.in_canReceive),  64'd0);
        chk("arst_out_isReady",    64'(bus.out_isReady),    64'd0);
        chk("arst_out",            bus.out,                 64'd0);
        @(negedge clk);
        rst = 1'b1;
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            step(1'b1, 16'h0EE0, 1'b1, in_f, out_f, o, lst, ordy, icr);
            if (ordy || lst) bad++;
        end
        chk("arst_no_output", 64'(bad), 64'd0);
        elem_q = '{16'h000A, 16'h000B, 16'h000C, 16'h000D};
        run_stream(1, 100, 100, n);
        chk("arst_new_word", got_q[0], 64'h000D_000C_000B_000A);
        chk("arst_new_last", 64'(last_q[0]), 64'd1);

        // Random stall: 64 words against the arithmetic model
        elem_q.delete();
        for (int i = 0; i < 256; i++) elem_q.push_back(16'($urandom));
        run_stream(64, 70, 60, n);
        lasts = 0;
        for (int w = 0; w < got_q.size(); w++) begin
            chk($sformatf("rand_word%0d", w), got_q[w], model_word(w));
            chk($sformatf("rand_last%0d", w), 64'(last_q[w]), 64'(w == 63));
            lasts += int'(last_q[w]);
        end
        chk("rand_last_count", 64'(lasts), 64'd1);

        chk("zero_when_invalid", 64'(zero_err), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
